// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the decode stage and the multiply/divide sequencer.
// The master side issues operations and mthi/mtlo writes; the slave side returns busy/done and HI/LO.
interface mdu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative mult/multu/div/divu controller sharing one add/subtract datapath over 32 steps.
// Holds the architectural HI/LO registers and serves mthi/mtlo writes while idle.
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic            clk,
    input logic            rst_n,
    mdu_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;

    logic               signed_in;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [IDX_W-1:0]   bit_idx;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   add_a, add_b, sum;
    logic               add_sub, borrow;
    logic [2*WIDTH-1:0] step_acc, prod;
    logic [WIDTH-1:0]   rem_raw, quo_raw, fix_hi, fix_lo;

    assign signed_in = ~bus.op[0];
    assign a_abs     = (signed_in && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs     = (signed_in && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign bit_idx   = cnt_q[IDX_W-1:0];
    assign shifted   = {acc_q[2*WIDTH-1:WIDTH], a_q[TOP_IDX - bit_idx]};

    // Single adder: subtraction folds in as invert-plus-one so both ops share it.
    assign sum    = add_a + (add_sub ? ~add_b : add_b) + {{(WIDTH+1){1'b0}}, add_sub};
    assign borrow = sum[WIDTH+1];

    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_sub  = 1'b0;
        step_acc = acc_q;
        if (op_q[1]) begin
            // Restoring divide: dividend enters MSB-first, quotient bits shift into the low half.
            add_a    = {1'b0, shifted};
            add_b    = {2'b00, b_q};
            add_sub  = 1'b1;
            step_acc = {(borrow ? shifted[WIDTH-1:0] : sum[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], ~borrow};
        end else begin
            add_a    = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
            add_b    = b_q[bit_idx] ? {2'b00, a_q} : '0;
            step_acc = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end
    end

    assign prod    = neg_q ? -acc_q : acc_q;
    assign rem_raw = acc_q[2*WIDTH-1:WIDTH];
    assign quo_raw = acc_q[WIDTH-1:0];

    always_comb begin
        if (op_q[1]) begin
            fix_hi = rneg_q ? -rem_raw : rem_raw;
            // A zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing.
            fix_lo = (b_q == '0) ? '1 : (neg_q ? -quo_raw : quo_raw);
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = bus.op;
                    a_d     = a_abs;
                    b_d     = b_abs;
                    acc_d   = '0;
                    neg_d   = signed_in & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    rneg_d  = signed_in & bus.A[WIDTH-1];
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Iterative multiply/divide unit controller for the MIPS core. It sequences a shared 33-bit add/subtract datapath over 32 iterations for mult, multu, div and divu, and holds the architectural HI/LO registers. The decode stage issues operations through a start/busy/done handshake. The mfhi/mflo/mthi/mtlo instructions access HI/LO directly.

Parameters:
WIDTH, 32, operand width; the only supported value is 32.
CNT_W, 6, iteration counter width.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  issue request; sampled only when busy=0
op  input  2  00 mult, 01 multu, 10 div, 11 divu
A  input  32  rs operand (multiplicand / dividend)
B  input  32  rt operand (multiplier / divisor)
hi_we  input  1  mthi write enable
lo_we  input  1  mtlo write enable
wdata  input  32  mthi/mtlo write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO updated with the result
HI  output  32  HI register (product high half / remainder)
LO  output  32  LO register (product low half / quotient)

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0. Reset mid-operation aborts the operation: no done pulse and no HI/LO update.
- States and transitions:
  - IDLE -> CALC on start=1.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE.
- IDLE:
  - At an edge with start=1, latch op and the operand magnitudes.
  - For signed ops (mult, div), magnitude = two's-complement absolute value; 0x80000000 stays 0x80000000 as unsigned.
  - Latch the result sign: mult = A[31]^B[31]; div quotient = A[31]^B[31]; div remainder = A[31].
  - Clear the 64-bit accumulator and set counter=0. busy=1 from the next cycle.
- CALC, multiply: shift-add, LSB-first, one multiplier bit per cycle. The 33-bit add keeps the carry in the accumulator high half.
- CALC, divide: restoring division, one quotient bit per cycle. Trial subtract uses the 33-bit adder; the remainder is restored when the borrow is set.
- CALC counter: increments each edge; leave CALC when counter=31 at an edge (32 CALC edges total).
- FIX:
  - Apply two's-complement negation to the 64-bit product or to the quotient/remainder per the latched signs.
  - Write HI/LO and drive done=1 and busy=0 in the following cycle. done lasts exactly one cycle.
- Latency: start sampled at edge k -> HI/LO valid and done=1 after edge k+33 (34 clocks). Throughput: one new start accepted in the cycle done is high.
- Divide by zero (B=0, any divide op): run full latency. Result HI=A (unmodified), LO=0xFFFFFFFF regardless of sign.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Arithmetic is modulo 2^64 (multiply) and 2^32 (divide); overflow is never flagged.
- start while busy=1: ignored, no queueing. Operands are captured at the accept edge only; changes on A/B during CALC have no effect.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we in IDLE: write wdata at that edge. hi_we and lo_we together write both registers.
- hi_we/lo_we in IDLE with start at the same edge: the write takes effect and start is accepted. The operation result later overwrites HI/LO.
- HI/LO hold their value through CALC until the FIX write, so mfhi/mflo read the previous values while busy=1.
- op values are all legal; no default/undefined result path exists.

Test Plan:
- Reset then multu A=0xFFFFFFFF, B=0xFFFFFFFF -> busy=1 for 33 cycles, done pulses once 34 clocks after start; HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=0xFFFFFFF9, B=2 -> LO=0x7FFFFFFC, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu A=100, B=0 -> after 34 clocks HI=0x00000064, LO=0xFFFFFFFF. div A=-5, B=0 -> HI=0xFFFFFFFB, LO=0xFFFFFFFF.
- Second start and hi_we pulse issued 5 cycles into a multu -> both ignored, result matches the first operation. mthi 0x12345678 in IDLE -> HI=0x12345678 next cycle, LO unchanged.
- rst_n=0 for one edge 10 cycles into a div -> busy=0, HI=LO=0, no done pulse. A new start immediately after completes correctly.
